alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the single-cycle ALU. It is the execute-stage arithmetic unit for the multi-cycle MIPS core. It keeps the existing AND/OR/ADD/SUB/SLT encodings and flag semantics and adds XOR, NOR, SLTU, and iterative unsigned multiply/divide producing a HI/LO pair. Operands are accepted on a valid/ready handshake and results are held until the consumer takes them.

## Interface
- DATA_WIDTH, 32, operand/result width; legal values are 4..64.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  unit can accept.
- A  input  DATA_WIDTH  operand A.
- B  input  DATA_WIDTH  operand B.
- ALUop  input  4  operation code.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer accepts result.
- Result  output  DATA_WIDTH  result, or LO/quotient.
- ResultHi  output  DATA_WIDTH  HI/remainder for MULTU/DIVU; 0 for other ops.
- Overflow  output  1  signed overflow (ADD/SUB) or divide-by-zero (DIVU).
- CarryOut  output  1  ADD: carry out of MSB; SUB: unsigned borrow (A<B).
- Zero  output  1  Result == 0, for every op.

## Operation
- **Opcodes:**
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed); 1000 SLTU; 1001 XOR; 1010 NOR; 1100 MULTU; 1101 DIVU.
  - Any other code performs AND with all flags 0.
- **Accept:** an operand is accepted when in_valid && in_ready. A, B and ALUop are captured at that point and are ignored afterwards.
- **States:**
  - IDLE: in_ready=1.
  - BUSY: iterative op running; in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- **Transitions:**
  - IDLE + accept of a single-cycle op → DONE.
  - IDLE + accept of MULTU/DIVU with B≠0 → BUSY, counter=0.
  - IDLE + accept of DIVU with B=0 → DONE.
  - BUSY with counter==DATA_WIDTH-1 → DONE.
  - DONE + out_ready with no new accept → IDLE.
  - DONE + out_ready + accept → handoff and accept happen in the same cycle. The next state follows the IDLE rules for the new op.
- **SLT/SLTU:** Result = {0…,less}.
  - SLT: less = sign(A−B) XOR overflow.
  - SLTU: less = borrow.
  - CarryOut and Overflow are 0 for both.
- **MULTU:** shift-add, one bit per cycle. Result is the low half and ResultHi the high half of the 2·DATA_WIDTH product. Flags Overflow=CarryOut=0; Zero applies to the low half only.
- **DIVU:** restoring division, one quotient bit per cycle. Result = quotient, ResultHi = remainder.
- **DIVU with B=0:** Result is all ones, ResultHi = A, Overflow=1.
- **Output hold:** all outputs are registered and stay stable while out_valid && !out_ready.
- **Reset:**
  - State IDLE, counter 0, out_valid 0.
  - Result, ResultHi and all flags 0.
  - in_ready is 1 in the first cycle after rst deasserts.
  - A reset during BUSY or DONE discards the operation; no result is ever presented for it.

## Timing
- **Single-cycle ops and DIVU-by-zero:** accept at edge N → out_valid high after edge N (latency 1).
- **MULTU/DIVU:** accept at edge N → BUSY through edge N+DATA_WIDTH → out_valid high after edge N+DATA_WIDTH (latency DATA_WIDTH+1; 33 at default).
- **Back-to-back throughput:** single-cycle ops sustain one result per cycle while out_ready=1 through DONE-state handoff.
- **Handshake independence:** in_ready is never combinationally dependent on in_valid. Only the dependence on out_ready in DONE is permitted.

## Structure
- **alu_pkg:** holds the opcode localparams (OP_AND … OP_DIVU) and the state encoding (S_IDLE, S_BUSY, S_DONE).
- **Sub-module mdu_iter:** holds the shared 2·DATA_WIDTH shift register, the DATA_WIDTH+1-bit adder/subtractor and the counter. It has start/done pulses and a mode input.
- **Top level:** holds the FSM, the single-cycle combinational datapath and the output registers.

## Test plan
All cases at DATA_WIDTH=32.
1. ADD 0x7FFFFFFF+0x00000001 → Result 0x80000000, Overflow 1, CarryOut 0, Zero 0; out_valid exactly 1 cycle after accept.
2. SUB 3−5 → 0xFFFFFFFE, CarryOut 1, Overflow 0. SLT 0x80000000,1 → 1. SLTU same operands → 0. SUB 7−7 → Zero 1.
3. MULTU 0xFFFFFFFF×0xFFFFFFFF → ResultHi 0xFFFFFFFE, Result 0x00000001. out_valid exactly 33 cycles after accept; in_ready 0 for those 32 BUSY cycles.
4. DIVU 100/7 → Result 14, ResultHi 2. DIVU 0x1234/0 → Result 0xFFFFFFFF, ResultHi 0x1234, Overflow 1, latency 1.
5. Backpressure:
   - Hold out_ready=0 for 5 cycles → all outputs stable.
   - Then raise out_ready with in_valid held (ADD 1+1) → handoff and accept occur on the same edge; next Result is 2 one cycle later.
6. Assert rst on the 10th BUSY cycle of MULTU → next cycle in_ready 1, out_valid 0, Result 0; no result appears over the following 40 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and multiply/divide mode for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic {
    M_MUL = 1'b0,
    M_DIV = 1'b1
  } mdu_mode_t;

  function automatic logic is_iter(logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the issue logic and the ALU.
interface alu_seq_if #(parameter int DATA_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [3:0]            ALUop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic [DATA_WIDTH-1:0] ResultHi;
  logic                  Overflow;
  logic                  CarryOut;
  logic                  Zero;

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, Result, ResultHi, Overflow, CarryOut, Zero
  );

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, Result, ResultHi, Overflow, CarryOut, Zero
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one shift register and adder.
// Latency: DATA_WIDTH cycles from i_start; o_done marks the last iteration, o_lo/o_hi are its final values.
// Backpressure: none; the caller only starts it when idle and captures the result on o_done.
module mdu_iter import alu_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  mdu_mode_t             i_mode,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic [DATA_WIDTH-1:0] o_hi
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  logic            r_busy;
  mdu_mode_t       r_mode;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic [W-1:0]    r_b;
  logic [W+1:0]    w_lhs;
  logic [W+1:0]    w_rhs;
  logic [W+1:0]    w_add;
  logic            w_cin;
  logic [W-1:0]    w_hi_nxt;
  logic [W-1:0]    w_lo_nxt;

  // Division subtracts via complement; the top bit of w_add is the borrow.
  always_comb begin
    w_cin = (r_mode == M_DIV);
    w_lhs = {2'b00, r_hi};
    w_rhs = r_lo[0] ? {2'b00, r_b} : '0;
    if (r_mode == M_DIV) begin
      w_lhs = {1'b0, r_hi, r_lo[W-1]};
      w_rhs = ~{2'b00, r_b};
    end
    w_add = w_lhs + w_rhs + {{(W+1){1'b0}}, w_cin};
  end

  always_comb begin
    w_hi_nxt = w_add[W:1];
    w_lo_nxt = {w_add[0], r_lo[W-1:1]};
    if (r_mode == M_DIV) begin
      if (!w_add[W+1]) begin
        w_hi_nxt = w_add[W-1:0];
        w_lo_nxt = {r_lo[W-2:0], 1'b1};
      end else begin
        w_hi_nxt = {r_hi[W-2:0], r_lo[W-1]};
        w_lo_nxt = {r_lo[W-2:0], 1'b0};
      end
    end
  end

  assign o_done = r_busy && (r_cnt == CW'(W - 1));
  assign o_lo   = w_lo_nxt;
  assign o_hi   = w_hi_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_mode <= M_MUL;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_mode <= i_mode;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= i_a;
      r_b    <= i_b;
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= o_done ? '0 : r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: logic/arith/compare in one cycle, MULTU/DIVU iterative into HI/LO.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, DATA_WIDTH+1 for MULTU/DIVU.
// Backpressure: results held while out_ready is low; in DONE a new operand is taken only with out_ready.
module alu_seq import alu_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  s_alu
);
  localparam int W = DATA_WIDTH;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_accept;
  logic         w_div0;
  logic         w_iter;
  logic         w_start;
  mdu_mode_t    w_mode;
  logic         w_mdu_done;
  logic [W-1:0] w_mdu_lo;
  logic [W-1:0] w_mdu_hi;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic         w_add_ovf;
  logic         w_sub_ovf;
  logic [W-1:0] w_res;
  logic         w_ovf;
  logic         w_cout;
  logic [W-1:0] r_res;
  logic [W-1:0] r_hi;
  logic         r_ovf;
  logic         r_cout;
  logic         r_zero;

  assign s_alu.in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && s_alu.out_ready);
  assign w_accept = s_alu.in_valid && s_alu.in_ready;
  assign w_div0   = (s_alu.ALUop == OP_DIVU) && (s_alu.B == '0);
  assign w_iter   = is_iter(s_alu.ALUop) && !w_div0;
  assign w_start  = w_accept && w_iter;
  assign w_mode   = (s_alu.ALUop == OP_DIVU) ? M_DIV : M_MUL;

  mdu_iter #(.DATA_WIDTH(W)) u_mdu (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_mode  (w_mode),
    .i_a     (s_alu.A),
    .i_b     (s_alu.B),
    .o_done  (w_mdu_done),
    .o_lo    (w_mdu_lo),
    .o_hi    (w_mdu_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // An accept in DONE implies out_ready, so handoff and the new op share the edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_iter ? S_BUSY : S_DONE;
      S_BUSY:  if (w_mdu_done) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_accept)             w_state_nxt = w_iter ? S_BUSY : S_DONE;
        else if (s_alu.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sum     = {1'b0, s_alu.A} + {1'b0, s_alu.B};
  assign w_diff    = {1'b0, s_alu.A} - {1'b0, s_alu.B};
  assign w_add_ovf = (s_alu.A[W-1] == s_alu.B[W-1]) && (w_sum[W-1] != s_alu.A[W-1]);
  assign w_sub_ovf = (s_alu.A[W-1] != s_alu.B[W-1]) && (w_diff[W-1] != s_alu.A[W-1]);

  always_comb begin
    w_res  = s_alu.A & s_alu.B;
    w_ovf  = 1'b0;
    w_cout = 1'b0;
    case (s_alu.ALUop)
      OP_AND:  w_res = s_alu.A & s_alu.B;
      OP_OR:   w_res = s_alu.A | s_alu.B;
      OP_ADD:  begin w_res = w_sum[W-1:0];  w_ovf = w_add_ovf; w_cout = w_sum[W];  end
      OP_SUB:  begin w_res = w_diff[W-1:0]; w_ovf = w_sub_ovf; w_cout = w_diff[W]; end
      OP_SLT:  w_res = {{(W-1){1'b0}}, w_diff[W-1] ^ w_sub_ovf};
      OP_SLTU: w_res = {{(W-1){1'b0}}, w_diff[W]};
      OP_XOR:  w_res = s_alu.A ^ s_alu.B;
      OP_NOR:  w_res = ~(s_alu.A | s_alu.B);
      OP_DIVU: begin w_res = '1; w_ovf = 1'b1; end
      default: w_res = s_alu.A & s_alu.B;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res  <= '0;
      r_hi   <= '0;
      r_ovf  <= 1'b0;
      r_cout <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept && !w_iter) begin
      r_res  <= w_res;
      r_hi   <= w_div0 ? s_alu.A : '0;
      r_ovf  <= w_ovf;
      r_cout <= w_cout;
      r_zero <= (w_res == '0);
    end else if (w_mdu_done && (r_state == S_BUSY)) begin
      r_res  <= w_mdu_lo;
      r_hi   <= w_mdu_hi;
      r_ovf  <= 1'b0;
      r_cout <= 1'b0;
      r_zero <= (w_mdu_lo == '0);
    end
  end

  assign s_alu.out_valid = (r_state == S_DONE);
  assign s_alu.Result    = r_res;
  assign s_alu.ResultHi  = r_hi;
  assign s_alu.Overflow  = r_ovf;
  assign s_alu.CarryOut  = r_cout;
  assign s_alu.Zero      = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases then randomized traffic with random backpressure.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ovf;
    logic        cout;
    logic        zero;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.DATA_WIDTH(W)) bus ();

  alu_seq #(.DATA_WIDTH(W)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .s_alu (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_val  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the opcode definitions using wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int acc);
    exp_t        e;
    longint      sa, sb_, r;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.hi = '0; e.ovf = 1'b0; e.cout = 1'b0; e.acc = acc; e.lat = 1;
    case (op)
      OP_AND: e.lo = a & b;
      OP_OR:  e.lo = a | b;
      OP_ADD: begin
        e.lo = a + b;
        t = {32'b0, a} + {32'b0, b};
        e.cout = t[32];
        r = sa + sb_;
        e.ovf = (r != longint'($signed(e.lo)));
      end
      OP_SUB: begin
        e.lo = a - b;
        e.cout = (a < b);
        r = sa - sb_;
        e.ovf = (r != longint'($signed(e.lo)));
      end
      OP_SLT:  e.lo = (sa < sb_) ? 32'd1 : 32'd0;
      OP_SLTU: e.lo = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  e.lo = a ^ b;
      OP_NOR:  e.lo = ~(a | b);
      OP_MULTU: begin
        t = {32'b0, a} * {32'b0, b};
        e.lo = t[31:0];
        e.hi = t[63:32];
        e.lat = W + 1;
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
          e.ovf = 1'b1;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
          e.lat = W + 1;
        end
      end
      default: e.lo = a & b;
    endcase
    e.zero = (e.lo == 32'd0);
    return e;
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_NOR, OP_MULTU, OP_DIVU};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Call at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.ALUop    = op;
    bus.A        = a;
    bus.B        = b;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      sb.push_back(model(op, a, b, cyc + 1));
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for op %0h, required 1", op);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = 32'($urandom);
    bus.B        = 32'($urandom);
    bus.ALUop    = 4'($urandom_range(0, 15));
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  // Monitor: pops on each newly presented result and checks that stalled outputs hold.
  bit          pv = 1'b0, pr = 1'b0;
  logic [31:0] s_lo, s_hi;
  logic [2:0]  s_fl;
  exp_t        m_e;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid",  64'(bus.out_valid), 64'(1));
        chk("hold_result", 64'(bus.Result), 64'(s_lo));
        chk("hold_hi",     64'(bus.ResultHi), 64'(s_hi));
        chk("hold_flags",  64'({bus.Overflow, bus.CarryOut, bus.Zero}), 64'(s_fl));
      end
      if (bus.out_valid && (!pv || pr)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: out_valid 1 with nothing pending, Result %0h", bus.Result);
        end else begin
          m_e = sb.pop_front();
          chk("result",   64'(bus.Result), 64'(m_e.lo));
          chk("result_hi", 64'(bus.ResultHi), 64'(m_e.hi));
          chk("overflow", 64'(bus.Overflow), 64'(m_e.ovf));
          chk("carryout", 64'(bus.CarryOut), 64'(m_e.cout));
          chk("zero",     64'(bus.Zero), 64'(m_e.zero));
          chk("latency",  64'(cyc - m_e.acc + 1), 64'(m_e.lat));
        end
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      s_lo = bus.Result;
      s_hi = bus.ResultHi;
      s_fl = {bus.Overflow, bus.CarryOut, bus.Zero};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    int vcnt;
    logic [3:0]  op;
    logic [31:0] a, b;

    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.ALUop = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_result",    64'(bus.Result), 64'(0));
    chk("rst_result_hi", 64'(bus.ResultHi), 64'(0));
    chk("rst_flags",     64'({bus.Overflow, bus.CarryOut, bus.Zero}), 64'(0));
    @(posedge clk);
    #1;

    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    send(OP_SUB, 32'd3, 32'd5);
    send(OP_SLT, 32'h8000_0000, 32'd1);
    send(OP_SLTU, 32'h8000_0000, 32'd1);
    send(OP_SUB, 32'd7, 32'd7);

    send(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_cnt = 0;
    repeat (W) begin
      @(negedge clk);
      if (!bus.in_ready) busy_cnt++;
    end
    chk("multu_busy_cycles", 64'(busy_cnt), 64'(W));
    @(posedge clk);
    #1;

    send(OP_DIVU, 32'd100, 32'd7);
    send(OP_DIVU, 32'h1234, 32'd0);

    repeat (2) @(posedge clk);
    #1 rdy_val = 1'b0;
    send(OP_ADD, 32'h1111, 32'h2222);
    repeat (5) @(posedge clk);
    #1 rdy_val = 1'b1;
    send(OP_ADD, 32'd1, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    send(OP_MULTU, 32'($urandom), 32'($urandom) | 32'd1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("busy_rst_in_ready",  64'(bus.in_ready), 64'(1));
    chk("busy_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("busy_rst_result",    64'(bus.Result), 64'(0));
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) vcnt++;
    end
    chk("busy_rst_no_result", 64'(vcnt), 64'(0));
    @(posedge clk);
    #1;

    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      op = 4'($urandom_range(0, 15));
      a = rnd_val();
      b = rnd_val();
      if (!is_legal(op)) begin
        a = a | 32'd1;
        b = a;
      end
      send(op, a, b);
    end

    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
